// File: rtl/i2s_transmitter.sv
// i2s_transmitter: FIFO-buffered Philips I2S serialiser, each sample sent on L and R.
// Optional macro I2S_UNDERRUN_HOLD_EN repeats the last sample on underrun instead of silence.
module i2s_transmitter #(
    parameter int WIDTH      = 24,
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            sample_in,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    output logic                        bclk,
    output logic                        lrclk,
    output logic                        sdata,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [DW-1:0]    div_q, div_d;
    logic [5:0]       b_q, b_d, b_inc;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             underrun_q, underrun_d;
    logic [WIDTH-1:0] frame_q, frame_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic        fall, rise, load, push, pop;
    logic [4:0]  slot_bit;
    logic [31:0] word;

    assign sample_ready = (lvl_q != LW'(FIFO_DEPTH));
    assign push         = sample_valid && sample_ready;
    assign fall         = (div_q == DW'(BCLK_DIV - 1));
    assign rise         = (div_q == DW'(BCLK_DIV / 2 - 1));
    assign load         = fall && (b_q == 6'd62);
    assign pop          = load && (lvl_q != '0);
    assign b_inc        = b_q + 6'd1;
    assign slot_bit     = b_inc[4:0];
    // Left-justify the sample in a 32-bit slot so bits past WIDTH read as zero.
    assign word         = 32'(frame_q) << (32 - WIDTH);

    always_comb begin
        div_d      = fall ? '0 : div_q + 1'b1;
        bclk_d     = bclk_q;
        b_d        = b_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        frame_d    = frame_q;
        underrun_d = 1'b0;
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        lvl_d      = lvl_q;

        if (rise) bclk_d = 1'b1;
        if (fall) begin
            bclk_d  = 1'b0;
            b_d     = b_inc;
            lrclk_d = (b_inc >= 6'd31) && (b_inc != 6'd63);
            sdata_d = (int'(slot_bit) < WIDTH) ? word[5'd31 - slot_bit] : 1'b0;
        end

        if (load) begin
            if (lvl_q != '0) begin
                frame_d = mem_q[rd_q];
            end else begin
`ifdef I2S_UNDERRUN_HOLD_EN
                frame_d = frame_q;
`else
                frame_d = '0;
`endif
                underrun_d = 1'b1;
            end
        end

        case ({push, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            b_q        <= 6'd63;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            frame_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            lvl_q      <= '0;
        end else begin
            div_q      <= div_d;
            b_q        <= b_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            frame_q    <= frame_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            lvl_q      <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= sample_in;
    end

    assign bclk       = bclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;
    assign underrun   = underrun_q;
    assign fifo_level = lvl_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: randomized/directed bench against a frame-level I2S model.
// Honours I2S_UNDERRUN_HOLD_EN the same way the design does.
module tb_i2s_transmitter;
    localparam int W     = 24;
    localparam int D     = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 64 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sample_in = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready, bclk, lrclk, sdata, underrun;
    logic [2:0]   fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    i2s_transmitter #(.WIDTH(W), .BCLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
        end
    endtask

    // Model: t = clocks since reset; bit position and bclk follow from t alone.
    int           m_t = 0;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_frame = '0;
    bit           m_und = 1'b0;

    always @(posedge clk) begin
        bit ld, pu;
        if (rst) begin
            m_t = 0;
            m_q.delete();
            m_frame = '0;
            m_und = 1'b0;
        end else begin
            pu = sample_valid && (m_q.size() != DEPTH);
            m_t++;
            ld = (m_t % D == 0) && ((m_t / D) % 64 == 0);
            m_und = 1'b0;
            if (ld) begin
                if (m_q.size() != 0) m_frame = m_q.pop_front();
                else begin
                    m_und = 1'b1;
`ifndef I2S_UNDERRUN_HOLD_EN
                    m_frame = '0;
`endif
                end
            end
            if (pu) m_q.push_back(sample_in);
        end
    end

    always @(negedge clk) begin
        int b, s;
        logic e_sd;
        b = (63 + m_t / D) % 64;
        s = b % 32;
        e_sd = (s < W) ? m_frame[W-1-s] : 1'b0;
        chk("bclk", bclk, (m_t % D) >= D / 2);
        chk("lrclk", lrclk, (b >= 31) && (b <= 62));
        chk("sdata", sdata, e_sd);
        chk("underrun", underrun, m_und);
        chk("level", fifo_level, m_q.size());
        chk("ready", sample_ready, m_q.size() != DEPTH);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push1(input logic [W-1:0] v);
        sample_valid = 1'b1;
        sample_in = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_t(input int target);
        int n = 0;
        while (m_t != target && n < 5000) begin
            tick();
            n++;
        end
        chk("wait_t", m_t, target);
    endtask

    initial begin
        int k, n;
        logic rdy;
        repeat (3) tick();
        rst = 1'b0;

        repeat (2 * FRAME + 40) tick();

        push1(24'h800001);
        repeat (2 * FRAME) tick();

        k = 1;
        repeat (5 * FRAME) begin
            sample_valid = 1'b1;
            sample_in = W'(k);
            rdy = sample_ready;
            tick();
            if (rdy) k++;
        end
        chk("bp_full", fifo_level, DEPTH);
        chk("bp_ready", sample_ready, 0);
        sample_valid = 1'b0;
        repeat (6 * FRAME) tick();

        push1(24'h123456);
        repeat (3 * FRAME) tick();

        push1(24'hABCDEF);
        push1(24'h654321);
        n = 0;
        while (((63 + m_t / D) % 64) != 40 && n < 2000) begin
            tick();
            n++;
        end
        chk("wait_b40", (63 + m_t / D) % 64, 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_level", fifo_level, 0);
        chk("rst_bclk", bclk, 0);
        chk("rst_ready", sample_ready, 1);

        push1(24'h111111);
        push1(24'h222222);
        wait_t(FRAME - 1);
        push1(24'h333333);
        chk("pp_level", fifo_level, 2);
        repeat (4 * FRAME) tick();

        repeat (4 * FRAME) begin
            sample_valid = ($urandom_range(0, 199) == 0);
            sample_in = W'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        repeat (FRAME) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serialises the synthesizer's mixed 24-bit signed sample stream onto a standard Philips I2S link for the board DAC. It sits downstream of the oscillator/mixer chain: it accepts one sample per audio frame through a valid/ready handshake and buffers it in a small FIFO. It generates BCLK and LRCLK by dividing the system clock and shifts each sample out MSB-first, duplicating it into the left and right slots.

## Interface
- `WIDTH`, 24: sample width in bits; must be ≤ 32.
- `BCLK_DIV`, 8: system clocks per BCLK period; even, ≥ 2.
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two, ≥ 2.

- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_in` in WIDTH: signed two's-complement sample.
- `sample_valid` in 1: `sample_in` is valid this cycle.
- `sample_ready` out 1: FIFO can accept a sample.
- `bclk` out 1: I2S bit clock.
- `lrclk` out 1: word select; 0 = left, 1 = right.
- `sdata` out 1: serial data.
- `underrun` out 1: one-cycle pulse when a frame starts with the FIFO empty.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push:** a sample is written when `sample_valid && sample_ready`. `sample_ready = (fifo_level != FIFO_DEPTH)`. It is computed from the registered level only, so no push occurs on a full FIFO even if a pop happens in the same cycle.
- **Divider:** counter `div` counts 0..BCLK_DIV-1 and wraps.
  - `bclk` rises when `div` reaches BCLK_DIV/2.
  - `bclk` falls when `div` wraps to 0.
- **Frame:** 64 BCLK periods, two 32-bit slots. Bit counter `b` (0..63, wraps) advances on every BCLK falling edge. All `sdata`/`lrclk` updates happen on falling edges only.
- **`lrclk`:** 0 for b ∈ {63, 0..30}; 1 for b ∈ 31..62. It changes one BCLK ahead of each slot's MSB, per I2S.
- **`sdata`:**
  - b ∈ 0..WIDTH-1: `frame[WIDTH-1-b]` (left slot).
  - b ∈ 32..32+WIDTH-1: `frame[WIDTH-1-(b-32)]` (right slot, same sample).
  - All other b: 0.
- **Load:** on the falling edge entering b=63:
  - FIFO non-empty: pop the head into `frame`.
  - FIFO empty: apply the underrun policy (see Configuration) and pulse `underrun` in that clk cycle.
- **Simultaneous push and pop with a non-full FIFO:** `fifo_level` is unchanged. FIFO order is preserved and pointers wrap modulo FIFO_DEPTH.
- **Output rate:** one sample consumed per frame, so the sample rate is clk/(64·BCLK_DIV).

## Timing
- **Reset values** (cycle after `rst` is sampled high, from any state, including mid-frame):
  - `bclk`=0, `lrclk`=0, `sdata`=0, `underrun`=0, `fifo_level`=0, `sample_ready`=1.
  - `div`=0, `b`=63, `frame`=0. The FIFO contents are discarded.
- **After reset deassertion:**
  - The first falling edge occurs BCLK_DIV cycles later and enters b=0.
  - The first load therefore happens at the 64th falling edge. Before that, a zero frame is transmitted with no `underrun` pulse.
- **Registered outputs:** `sdata`/`lrclk` change in the same clk cycle as `bclk` falls, so they are stable for a full BCLK period around each rising edge.
- **Latency:** a sample pushed into an empty FIFO before the b=63 edge appears as the left MSB at the next b=0 falling edge.
- **`sample_ready`:** updates one cycle after a push or pop.

## Configuration
- Macro `I2S_UNDERRUN_HOLD_EN`.
  - Defined: on underrun, `frame` keeps its previous value, so the last sample is repeated.
  - Undefined: on underrun, `frame` is loaded with 0 (silence).
  - `underrun` pulses in both builds.

## Test plan
- **Reset idle:** reset, then no input for 2 frames (BCLK_DIV=8) → `bclk` period 8 clk. `lrclk` low for 32 BCLKs then high for 32. `sdata` all 0. `underrun` pulses once per frame from the 2nd frame on.
- **Single sample:** push 24'h800001 at start of frame → next frame `sdata` left = 1,0×22,1, then 8 zeros. The right slot carries the same bits. `lrclk` toggles one BCLK before each MSB.
- **Backpressure:** hold `sample_valid`=1 with incrementing samples 1,2,3,… → `fifo_level` reaches 4 and `sample_ready` drops. Samples emerge in order 1,2,3,4,5, one per frame, with none lost or duplicated.
- **Underrun policy:** push 24'h123456, then stop. Build with `I2S_UNDERRUN_HOLD_EN` → following frames repeat 123456 with `underrun` pulsing. Build without it → following frames are zero.
- **Mid-frame reset:** assert `rst` for 1 cycle at b=40 → all outputs at reset values the next cycle, `fifo_level`=0, and the frame restarts cleanly from b=63.
- **Simultaneous push/pop:** push a sample in the exact cycle of the b=63 pop with `fifo_level`=2 → `fifo_level` stays 2 and output order is preserved.
